window_fetch: RTL

Initiator for the 9-tap parallel RAM read port (`ramControl`). It scans a feature map stored row-major in that RAM and, for each output position, computes the nine 3x3 window addresses and issues one `start` request. It captures the 90-bit response, zeroes taps that fall in the padding region, and presents the window to the convolution datapath with a valid/ready handshake. It sits between `ramControl` and the depthwise/pointwise MAC stage.

---
 rtl/mobilenet_pkg.sv | 26 ++
 rtl/window_addr_calc.sv | 47 ++++
 rtl/window_fetch.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mobilenet_pkg.sv
// Shared definitions for the MobileNet convolution front end.
//   ADDR_W / DATA_W / NUM_TAP : RAM address width, pixel width, 3x3 tap count
//   fetch_state_t             : window_fetch controller states
//   tap_slice()               : extracts tap k from a packed NUM_TAP*DATA_W bus
package mobilenet_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 10;
    localparam int NUM_TAP = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } fetch_state_t;

    function automatic logic [DATA_W-1:0] tap_slice(
        input logic [NUM_TAP*DATA_W-1:0] bus,
        input int                        k
    );
        return bus[k*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/window_addr_calc.sv
// Combinational 3x3 window address generator.
//   row, col : output-position indices of the window
//   base     : RAM address of pixel (0,0)
//   addr     : nine 12-bit tap addresses, tap k at [12k+11:12k]
//   pad_mask : bit k set when tap k lies in the zero-padding border
// Padding taps are pointed at base so the RAM always sees a legal address.
module window_addr_calc
    import mobilenet_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int STRIDE = 1,
    parameter int PAD    = 1
) (
    input  logic [ADDR_W-1:0]         row,
    input  logic [ADDR_W-1:0]         col,
    input  logic [ADDR_W-1:0]         base,
    output logic [NUM_TAP*ADDR_W-1:0] addr,
    output logic [NUM_TAP-1:0]        pad_mask
);

    localparam logic signed [13:0] STRIDE_S = 14'(STRIDE);
    localparam logic signed [13:0] PAD_S    = 14'(PAD);
    localparam logic signed [13:0] ROW_MAX  = 14'(IMG_H - 1);
    localparam logic signed [13:0] COL_MAX  = 14'(IMG_W - 1);
    localparam logic [ADDR_W-1:0]  WIDTH_A  = ADDR_W'(IMG_W);

    for (genvar k = 0; k < NUM_TAP; k++) begin : g_tap
        localparam logic signed [13:0] DR = 14'(k / 3);
        localparam logic signed [13:0] DC = 14'(k % 3);

        logic signed [13:0] r;
        logic signed [13:0] c;
        logic               pad;
        logic [ADDR_W-1:0]  lin;

        assign r   = $signed({2'b00, row}) * STRIDE_S + DR - PAD_S;
        assign c   = $signed({2'b00, col}) * STRIDE_S + DC - PAD_S;
        assign pad = (r < 14'sd0) || (r > ROW_MAX) || (c < 14'sd0) || (c > COL_MAX);
        // r and c are non-negative whenever lin is used; 12-bit wrap is intended.
        assign lin = base + r[ADDR_W-1:0] * WIDTH_A + c[ADDR_W-1:0];

        assign addr[k*ADDR_W +: ADDR_W] = pad ? base : lin;
        assign pad_mask[k]              = pad;
    end

endmodule

// File: rtl/window_fetch.sv
// Window fetch initiator for the 9-tap parallel RAM read port.
// Scans the feature map, requests each 3x3 window from the RAM, zeroes
// padding taps and hands the window to the MAC stage with valid/ready.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_go, i_baseAddr     : scan start pulse and map base address
//   o_addrOut, o_start   : RAM request (9 packed addresses, 1-cycle pulse)
//   i_ready, i_data, i_valid : RAM idle flag and response
//   o_window, o_padMask, o_row, o_col, o_winValid, i_winReady : window out
//   o_busy, o_done       : scan status
//
// state    | meaning
// ST_IDLE  | waiting for i_go
// ST_ISSUE | waiting for RAM idle, then launch request
// ST_WAIT  | request outstanding, capture first i_valid
// ST_OUT   | window presented, waiting for consumer
// ST_DONE  | one-cycle completion pulse
module window_fetch
    import mobilenet_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int STRIDE = 1,
    parameter int PAD    = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_go,
    input  logic [ADDR_W-1:0]             i_baseAddr,
    output logic [NUM_TAP*ADDR_W:0]       o_addrOut,
    output logic                          o_start,
    input  logic                          i_ready,
    input  logic [NUM_TAP*DATA_W-1:0]     i_data,
    input  logic                          i_valid,
    output logic [NUM_TAP*DATA_W-1:0]     o_window,
    output logic [NUM_TAP-1:0]            o_padMask,
    output logic [ADDR_W-1:0]             o_row,
    output logic [ADDR_W-1:0]             o_col,
    output logic                          o_winValid,
    input  logic                          i_winReady,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int OUT_W = (IMG_W + 2 * PAD - 3) / STRIDE + 1;
    localparam int OUT_H = (IMG_H + 2 * PAD - 3) / STRIDE + 1;
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(OUT_H - 1);

    fetch_state_t              state;
    fetch_state_t              state_n;
    logic [ADDR_W-1:0]         base_q;
    logic [ADDR_W-1:0]         row_q;
    logic [ADDR_W-1:0]         col_q;
    logic [NUM_TAP-1:0]        mask_q;
    logic [NUM_TAP-1:0]        calc_mask;
    logic [NUM_TAP*ADDR_W-1:0] calc_addr;
    logic [NUM_TAP*DATA_W-1:0] win_masked;
    logic                      last_pos;

    window_addr_calc #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .STRIDE (STRIDE),
        .PAD    (PAD)
    ) u_addr_calc (
        .row      (row_q),
        .col      (col_q),
        .base     (base_q),
        .addr     (calc_addr),
        .pad_mask (calc_mask)
    );

    assign last_pos = (row_q == LAST_ROW) && (col_q == LAST_COL);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (i_go)       state_n = ST_ISSUE;
            ST_ISSUE: if (i_ready)    state_n = ST_WAIT;
            ST_WAIT:  if (i_valid)    state_n = ST_OUT;
            ST_OUT:   if (i_winReady) state_n = last_pos ? ST_DONE : ST_ISSUE;
            ST_DONE:                  state_n = ST_IDLE;
            default:                  state_n = ST_IDLE;
        endcase
    end

    assign o_winValid = (state == ST_OUT);
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);

    always_comb begin
        win_masked = '0;
        for (int k = 0; k < NUM_TAP; k++) begin
            win_masked[k*DATA_W +: DATA_W] = mask_q[k] ? '0 : tap_slice(i_data, k);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            base_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            mask_q    <= '0;
            o_addrOut <= '0;
            o_start   <= 1'b0;
            o_window  <= '0;
            o_padMask <= '0;
            o_row     <= '0;
            o_col     <= '0;
        end else begin
            o_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_go) begin
                        base_q <= i_baseAddr;
                        row_q  <= '0;
                        col_q  <= '0;
                    end
                end
                ST_ISSUE: begin
                    // Address bus is captured once and held until the next request.
                    if (i_ready) begin
                        o_start   <= 1'b1;
                        o_addrOut <= {1'b0, calc_addr};
                        mask_q    <= calc_mask;
                    end
                end
                ST_WAIT: begin
                    if (i_valid) begin
                        o_window  <= win_masked;
                        o_padMask <= mask_q;
                        o_row     <= row_q;
                        o_col     <= col_q;
                    end
                end
                ST_OUT: begin
                    if (i_winReady) begin
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + 12'd1;
                        end else begin
                            col_q <= col_q + 12'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
